// File: rtl/food_placer.sv
// -----------------------------------------------------------------------------
// FoodPlacer -- places the snake's food on a free, in-range cell.
//
// On a placement request the block pulses `drive` to the random box
// generator, waits RND_LAT cycles, latches the candidate, range-checks it
// and then streams the snake body memory (one segment per cycle, 1-cycle
// read latency) looking for an overlap. A rejected candidate triggers a new
// draw until MAX_TRY draws have been spent, after which `place_fail` pulses.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   place_req           placement request (honoured only when idle)
//   snake_len           segment count, latched and clamped to MAX_LEN
//   drive               1-cycle request pulse to random_box
//   box_x, box_y        candidate coordinates from random_box
//   seg_idx             body memory read address
//   seg_x, seg_y        body memory read data (1-cycle latency)
//   food_x, food_y      last committed food position (registered)
//   food_valid          food position valid
//   busy                high whenever not idle
//   place_done          1-cycle pulse on successful commit
//   place_fail          1-cycle pulse when all draws were rejected
//
// Optional build macro FOOD_TRY_STATS_EN adds:
//   last_tries [3:0]      draws used by the last completed placement
//   total_retries [15:0]  saturating count of rejected draws since reset
// -----------------------------------------------------------------------------
module food_placer #(
    parameter int COORD_W = 10,
    parameter int MAX_LEN = 64,
    parameter int IDX_W   = 6,
    parameter int RND_LAT = 2,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 630,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 470,
    parameter int MAX_TRY = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               place_req,
    input  logic [IDX_W:0]     snake_len,
    output logic               drive,
    input  logic [COORD_W-1:0] box_x,
    input  logic [COORD_W-1:0] box_y,
    output logic [IDX_W-1:0]   seg_idx,
    input  logic [COORD_W-1:0] seg_x,
    input  logic [COORD_W-1:0] seg_y,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid,
    output logic               busy,
    output logic               place_done,
    output logic               place_fail
`ifdef FOOD_TRY_STATS_EN
    ,
    output logic [3:0]         last_tries,
    output logic [15:0]        total_retries
`endif
);

    localparam int WAIT_W = (RND_LAT > 1) ? $clog2(RND_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RND_LAT - 1);
    localparam logic [IDX_W:0]    LEN_CAP   = (IDX_W + 1)'(MAX_LEN);
    localparam logic [3:0]        TRY_CAP   = 4'(MAX_TRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_BOUND,
        S_SCAN,
        S_FAIL
    } state_t;

    state_t               r_state;
    logic [3:0]           r_try;
    logic [IDX_W:0]       r_len;
    logic [WAIT_W-1:0]    r_wait;
    logic [COORD_W-1:0]   r_candX;
    logic [COORD_W-1:0]   r_candY;
    // seg_x/seg_y lag seg_idx by one cycle; these remember which segment
    // the memory data currently belongs to and whether it is meaningful yet.
    logic                 r_cmpValid;
    logic [IDX_W-1:0]     r_cmpIdx;

    logic                 w_outOfRange;
    logic                 w_hit;
    logic [IDX_W:0]       w_lastIdx;
    logic                 w_cmpLast;
    logic                 w_segAtEnd;
    logic [IDX_W:0]       w_lenClamp;
    logic                 w_reject;
    logic                 w_commit;
    logic                 w_tryLast;

    // Casting to int keeps the range compares signed, so a zero lower bound
    // does not turn into an always-false unsigned compare.
    assign w_outOfRange = (int'(r_candX) < X_MIN) || (int'(r_candX) > X_MAX) ||
                          (int'(r_candY) < Y_MIN) || (int'(r_candY) > Y_MAX);
    assign w_hit        = (seg_x == r_candX) && (seg_y == r_candY);
    assign w_lastIdx    = r_len - 1'b1;
    assign w_cmpLast    = ({1'b0, r_cmpIdx} == w_lastIdx);
    assign w_segAtEnd   = ({1'b0, seg_idx} == w_lastIdx);
    assign w_lenClamp   = (snake_len > LEN_CAP) ? LEN_CAP : snake_len;
    assign w_tryLast    = (r_try == TRY_CAP);

    // A draw ends either rejected (out of range, or a body hit) or
    // committed (in range with an empty body, or the last segment clean).
    assign w_reject = ((r_state == S_BOUND) && w_outOfRange) ||
                      ((r_state == S_SCAN) && r_cmpValid && w_hit);
    assign w_commit = ((r_state == S_BOUND) && !w_outOfRange && (r_len == '0)) ||
                      ((r_state == S_SCAN) && r_cmpValid && !w_hit && w_cmpLast);

    // Main controller: every output is registered here, and the pulse
    // outputs default low so each can only be high for a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_try      <= '0;
            r_len      <= '0;
            r_wait     <= '0;
            r_candX    <= '0;
            r_candY    <= '0;
            r_cmpValid <= 1'b0;
            r_cmpIdx   <= '0;
            drive      <= 1'b0;
            seg_idx    <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            busy       <= 1'b0;
            place_done <= 1'b0;
            place_fail <= 1'b0;
        end else begin
            drive      <= 1'b0;
            place_done <= 1'b0;
            place_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (place_req) begin
                        food_valid <= 1'b0;
                        r_try      <= 4'd1;
                        r_len      <= w_lenClamp;
                        drive      <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_wait  <= WAIT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_candX <= box_x;
                        r_candY <= box_y;
                        r_state <= S_BOUND;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_BOUND, S_SCAN: begin
                    if (w_reject) begin
                        if (w_tryLast) begin
                            place_fail <= 1'b1;
                            r_state    <= S_FAIL;
                        end else begin
                            r_try   <= r_try + 4'd1;
                            drive   <= 1'b1;
                            r_state <= S_DRIVE;
                        end
                    end else if (w_commit) begin
                        food_x     <= r_candX;
                        food_y     <= r_candY;
                        food_valid <= 1'b1;
                        place_done <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_state == S_BOUND) begin
                        seg_idx    <= '0;
                        r_cmpValid <= 1'b0;
                        r_state    <= S_SCAN;
                    end else begin
                        // Address issued this cycle is compared next cycle;
                        // the address parks on the last segment.
                        r_cmpValid <= 1'b1;
                        r_cmpIdx   <= seg_idx;
                        if (!w_segAtEnd) begin
                            seg_idx <= seg_idx + 1'b1;
                        end
                    end
                end
                S_FAIL: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FOOD_TRY_STATS_EN
    // Draw statistics: the try count is captured whenever a placement
    // finishes (commit or final reject), and every rejected draw is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_tries    <= '0;
            total_retries <= '0;
        end else begin
            if (w_commit || (w_reject && w_tryLast)) begin
                last_tries <= r_try;
            end
            if (w_reject && (total_retries != 16'hFFFF)) begin
                total_retries <= total_retries + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_food_placer.sv
// -----------------------------------------------------------------------------
// TbFoodPlacer -- self-checking bench for food_placer with default parameters.
// Models random_box (replays a candidate plan, one entry per drive pulse)
// and the body memory (1-cycle read latency). Expected results come from a
// directed table and from a placement-level reference model.
// -----------------------------------------------------------------------------
module tb_food_placer;

    localparam int LAT   = 2;
    localparam int XMAX  = 630;
    localparam int YMAX  = 470;
    localparam int MLEN  = 64;
    localparam int TRIES = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       place_req = 1'b0;
    logic [6:0] snake_len = '0;
    logic       drive;
    logic [9:0] box_x = '0;
    logic [9:0] box_y = '0;
    logic [5:0] seg_idx;
    logic [9:0] seg_x = '0;
    logic [9:0] seg_y = '0;
    logic [9:0] food_x;
    logic [9:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       place_done;
    logic       place_fail;
`ifdef FOOD_TRY_STATS_EN
    logic [3:0]  last_tries;
    logic [15:0] total_retries;
`endif

    int total = 0;
    int bad = 0;

    int memX[64];
    int memY[64];
    int planX[16];
    int planY[16];
    int planN = 1;
    int planBase = 0;
    int driveCount = 0;

    int lastFx = 0;
    int lastFy = 0;
    int expRetries = 0;

    typedef struct {
        string name;
        int    snakeLen;
        int    nCand;
        int    cx0;
        int    cy0;
        int    cx1;
        int    cy1;
        int    collideIdx;
        bit    expFail;
        int    expFx;
        int    expFy;
        int    expDrives;
        int    expLat;
        int    expSegMoves;
    } vec_t;

    vec_t vecs[7];

    food_placer dut (
        .clk          (clk),
        .rst          (rst),
        .place_req    (place_req),
        .snake_len    (snake_len),
        .drive        (drive),
        .box_x        (box_x),
        .box_y        (box_y),
        .seg_idx      (seg_idx),
        .seg_x        (seg_x),
        .seg_y        (seg_y),
        .food_x       (food_x),
        .food_y       (food_y),
        .food_valid   (food_valid),
        .busy         (busy),
        .place_done   (place_done),
        .place_fail   (place_fail)
`ifdef FOOD_TRY_STATS_EN
        ,
        .last_tries   (last_tries),
        .total_retries(total_retries)
`endif
    );

    always #5 clk = ~clk;

    // Body memory: registered read of the addressed segment.
    always @(posedge clk) begin
        seg_x <= 10'(memX[seg_idx]);
        seg_y <= 10'(memY[seg_idx]);
    end

    // random_box stand-in: each drive pulse presents the next plan entry,
    // repeating the final entry once the plan is exhausted.
    always @(posedge clk) begin
        int idx;
        if (drive) begin
            idx = driveCount - planBase;
            if (idx >= planN) idx = planN - 1;
            box_x <= 10'(planX[idx]);
            box_y <= 10'(planY[idx]);
            driveCount <= driveCount + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic defaultBody();
        for (int i = 0; i < 64; i++) begin
            memX[i] = 10 * i;
            memY[i] = 0;
        end
    endtask

    // Placement-level reference: walk the draws, each costing the cycles
    // from its DRIVE entry to its decision edge.
    function automatic void model(input int snakeLen, output bit fail, output int fx,
                                  output int fy, output int draws, output int lat);
        int eff;
        int cx;
        int cy;
        int hit;
        eff = (snakeLen > MLEN) ? MLEN : snakeLen;
        lat = 0;
        fail = 1'b1;
        fx = 0;
        fy = 0;
        draws = TRIES;
        for (int t = 0; t < TRIES; t++) begin
            cx = planX[(t < planN) ? t : planN - 1];
            cy = planY[(t < planN) ? t : planN - 1];
            if (cx > XMAX || cy > YMAX) begin
                lat += 2 + LAT;
                continue;
            end
            if (eff == 0) begin
                lat += 2 + LAT;
                fail = 1'b0; fx = cx; fy = cy; draws = t + 1;
                break;
            end
            hit = -1;
            for (int k = 0; k < eff; k++) begin
                if (memX[k] == cx && memY[k] == cy) begin
                    hit = k;
                    break;
                end
            end
            if (hit >= 0) begin
                lat += 4 + LAT + hit;
                continue;
            end
            lat += 3 + LAT + eff;
            fail = 1'b0; fx = cx; fy = cy; draws = t + 1;
            break;
        end
    endfunction

    // Issues one placement request and observes until food_valid or
    // place_fail, sampling 1 time unit after each rising edge.
    task automatic applyStimulus(input int snakeLen, output int lat, output int drives,
                                 output int segMoves, output bit failed);
        int prevSeg;
        bit timedOut;
        @(negedge clk);
        planBase = driveCount;
        snake_len = 7'(snakeLen);
        place_req = 1'b1;
        @(posedge clk);
        #1;
        place_req = 1'b0;
        snake_len = 7'($urandom);
        drives = 0;
        segMoves = 0;
        prevSeg = int'(seg_idx);
        lat = -1;
        failed = 1'b0;
        timedOut = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (drive) drives++;
            if (int'(seg_idx) != prevSeg) segMoves++;
            prevSeg = int'(seg_idx);
            if (food_valid || place_fail) begin
                lat = c;
                failed = place_fail;
                timedOut = 1'b0;
                break;
            end
        end
        if (timedOut) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: got no completion expected completion within 3000 cycles");
        end
    endtask

    task automatic runCase(input string name, input int snakeLen, input bit expFail,
                           input int expFx, input int expFy, input int expDrives,
                           input int expLat, input int expSegMoves);
        int lat;
        int drives;
        int segMoves;
        bit failed;
        applyStimulus(snakeLen, lat, drives, segMoves, failed);
        if (!expFail) begin
            lastFx = expFx;
            lastFy = expFy;
        end
        checkOutput({name, " latency"}, lat, expLat);
        checkOutput({name, " drives"}, drives, expDrives);
        checkOutput({name, " fail"}, int'(failed), int'(expFail));
        checkOutput({name, " food_valid"}, int'(food_valid), int'(!expFail));
        checkOutput({name, " place_done"}, int'(place_done), int'(!expFail));
        checkOutput({name, " food_x"}, int'(food_x), lastFx);
        checkOutput({name, " food_y"}, int'(food_y), lastFy);
        checkOutput({name, " busy"}, int'(busy), int'(expFail));
        if (expSegMoves >= 0) checkOutput({name, " seg_moves"}, segMoves, expSegMoves);
`ifdef FOOD_TRY_STATS_EN
        expRetries += expDrives - (expFail ? 0 : 1);
        checkOutput({name, " last_tries"}, int'(last_tries), expDrives);
        checkOutput({name, " total_retries"}, int'(total_retries), expRetries);
`endif
        @(posedge clk);
        #1;
        checkOutput({name, " busy after"}, int'(busy), 0);
        checkOutput({name, " pulses cleared"}, int'(place_done) + int'(place_fail), 0);
        @(posedge clk);
    endtask

    initial begin
        vecs[0] = '{"nominal",  3,   1, 100, 200,   0,   0, -1, 1'b0, 100, 200, 1,  8, -1};
        vecs[1] = '{"body_hit", 3,   2, 300, 300,  50,  60,  1, 1'b0,  50,  60, 2, 15, -1};
        vecs[2] = '{"x_range",  3,   2, 700,  10,  60,  70, -1, 1'b0,  60,  70, 2, 12, -1};
        vecs[3] = '{"y_range",  2,   2,  10, 471, 630, 470, -1, 1'b0, 630, 470, 2, 11, -1};
        vecs[4] = '{"len_zero", 0,   1,  40,  40,   0,   0, -1, 1'b0,  40,  40, 1,  4,  0};
        vecs[5] = '{"head_hit", 1,   2,   0,   0,   5,   5, -1, 1'b0,   5,   5, 2, 12, -1};
        vecs[6] = '{"len_clamp",100, 1,   1,   1,   0,   0, -1, 1'b0,   1,   1, 1, 69, -1};

        defaultBody();
        planX[0] = 0;
        planY[0] = 0;

        // Reset and idle: nothing moves without a request.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int drv = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                if (drive) drv++;
            end
            checkOutput("idle drives", drv, 0);
            checkOutput("reset outputs", int'(food_valid) + int'(busy) + int'(place_done) +
                        int'(place_fail) + int'(food_x) + int'(food_y) + int'(seg_idx), 0);
        end

        // Directed vectors.
        for (int v = 0; v < 7; v++) begin
            defaultBody();
            if (vecs[v].collideIdx >= 0) begin
                memX[vecs[v].collideIdx] = vecs[v].cx0;
                memY[vecs[v].collideIdx] = vecs[v].cy0;
            end
            planX[0] = vecs[v].cx0;
            planY[0] = vecs[v].cy0;
            planX[1] = vecs[v].cx1;
            planY[1] = vecs[v].cy1;
            planN = vecs[v].nCand;
            runCase(vecs[v].name, vecs[v].snakeLen, vecs[v].expFail, vecs[v].expFx,
                    vecs[v].expFy, vecs[v].expDrives, vecs[v].expLat, vecs[v].expSegMoves);
        end

        // Every draw collides with the head: 15 draws of 6 cycles, then fail.
        defaultBody();
        memX[0] = 300;
        memY[0] = 300;
        planX[0] = 300;
        planY[0] = 300;
        planN = 1;
        runCase("exhaust", 1, 1'b1, 0, 0, 15, 90, -1);

        // Reset in the middle of a scan, then a normal placement.
        defaultBody();
        planX[0] = 100;
        planY[0] = 100;
        planN = 1;
        @(negedge clk);
        planBase = driveCount;
        snake_len = 7'd10;
        place_req = 1'b1;
        @(posedge clk);
        #1;
        place_req = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midscan reset outputs", int'(drive) + int'(food_valid) + int'(busy) +
                    int'(place_done) + int'(place_fail) + int'(food_x) + int'(food_y) +
                    int'(seg_idx), 0);
        lastFx = 0;
        lastFy = 0;
        expRetries = 0;
`ifdef FOOD_TRY_STATS_EN
        checkOutput("midscan reset stats", int'(last_tries) + int'(total_retries), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        runCase("after_reset", 10, 1'b0, 100, 100, 1, 15, -1);

        // Randomized placements against the reference model.
        for (int n = 0; n < 40; n++) begin
            int len;
            bit eFail;
            int eFx;
            int eFy;
            int eDraws;
            int eLat;
            for (int i = 0; i < 64; i++) begin
                memX[i] = $urandom_range(0, 3);
                memY[i] = $urandom_range(0, 3);
            end
            for (int t = 0; t < 15; t++) begin
                planX[t] = ($urandom_range(0, 9) == 0) ? 631 : $urandom_range(0, 3);
                planY[t] = ($urandom_range(0, 9) == 0) ? 471 : $urandom_range(0, 3);
            end
            planN = 15;
            len = $urandom_range(0, 7);
            model(len, eFail, eFx, eFy, eDraws, eLat);
            runCase($sformatf("rand%0d", n), len, eFail, eFx, eFy, eDraws, eLat, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no end of test expected end before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
